sfif_tag_pool: RTL and testbench
================================

# sfif_tag_pool

Parametrised non-posted tag manager for the SFIF PCIe traffic path, in the clk_125 domain between the TX request sequencer and the RX completion path. Successor to the fixed single-count tag check: it allocates up to NUM_TAGS concurrent read tags and tracks the remaining completion data per tag. It retires tags on final completion or on timeout, and flags unexpected or overrunning completions. The outputs drive the TX tag-available gate and the debug/statistics counters.

## Interface
- NUM_TAGS, 32, number of tags, 2..2**TAG_W
- TAG_W, 5, tag field width
- LEN_W, 10, DW length field width; a value of 0 encodes 2**LEN_W DW (PCIe rule)
- TO_W, 16, per-tag age counter width
- TIMEOUT, 50000, age in cycles at which a tag expires; 1..2**TO_W-1
- clk_125  in  1  clock
- rstn  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of all tag state
- alloc_req  in  1  request for a tag for a non-posted TLP
- alloc_len  in  LEN_W  DW count requested
- alloc_gnt  out  1  grant; equals alloc_req & tag_avail (combinational)
- alloc_tag  out  TAG_W  lowest free tag index (combinational)
- tag_avail  out  1  at least one tag free (combinational from registered bitmap)
- cpl_val  in  1  completion header strobe, one cycle per CplD TLP
- cpl_tag  in  TAG_W  completion tag
- cpl_len  in  LEN_W  completion payload DW (0 encodes 2**LEN_W)
- done_val  out  1  pulse: tag retired normally
- done_tag  out  TAG_W  tag retired
- to_val  out  1  pulse: tag retired by timeout
- to_tag  out  TAG_W  tag timed out
- cpl_err  out  1  pulse: unexpected tag or length overrun
- outstanding  out  TAG_W+1  number of allocated tags

## Operation
- State per tag: busy bit, expired bit, remaining DW (LEN_W+1 bits), age (TO_W bits).
- Allocate on the alloc_gnt edge: busy=1, expired=0, age=0, remaining=alloc_len (0 maps to 2**LEN_W).
- Completion with cpl_val:
  - Tag not busy, or cpl_tag >= NUM_TAGS: set cpl_err; no state change.
  - cpl_len < remaining: subtract cpl_len from remaining.
  - cpl_len >= remaining: clear busy and expired, and pulse done.
  - cpl_len > remaining: also pulse cpl_err (overrun).
- Ageing:
  - Each busy, non-expired tag increments age every cycle.
  - At age==TIMEOUT-1 the tag sets expired and age stops.
  - Each cycle the lowest-index expired tag is reported on to_val/to_tag and freed (busy=0, expired=0). Other expired tags wait for later cycles.
- A completion to an expired tag that has not yet been reported is processed normally. If that completion retires the tag, the timeout report is cancelled.
- outstanding = popcount(busy), registered.
- flush clears all state and all pulses on the next edge; alloc_gnt is forced to 0 while flush=1.

## Timing
- Reset values: busy, expired, remaining, age, done_val, to_val, cpl_err, outstanding = 0; done_tag, to_tag = 0.
  - Hence tag_avail=1 and alloc_tag=0 out of reset.
- alloc_gnt/alloc_tag have zero latency. busy is set at the grant edge, so tag_avail and outstanding update one cycle later.
- done_val, cpl_err, to_val are registered single-cycle pulses, asserted the cycle after the causing event.
- A tag freed at edge N (by done or timeout) is grantable from the cycle after edge N, never in the same cycle it frees.
- alloc_req with cpl_val in the same cycle: both take effect. They touch different tags by construction, since the granted tag is not busy.
- done and timeout on different tags in the same cycle: both are reported in the same cycle on separate outputs.
- Pool full (outstanding==NUM_TAGS): tag_avail=0 and alloc_gnt=0; alloc_req is ignored, not queued.
- Age is compared against TIMEOUT-1, so expiry is reported exactly TIMEOUT+1 cycles after the grant edge. No wrap, since age stops at expiry.
- rstn asserted mid-operation: all state clears immediately; any pulse in flight is dropped.

## Test plan
- Reset, then alloc_req with alloc_len=4 for 3 cycles -> grants tags 0,1,2; outstanding=3 in the cycle after the third grant.
- Tag 1 with alloc_len=8, then cpl 5 DW and cpl 3 DW -> done_val with done_tag=1 one cycle after the second cpl; no cpl_err; tag 1 regranted next.
- cpl to a free tag 7, and a cpl_len=6 against remaining 4 -> cpl_err in both cases; the overrun also gives done_val for that tag.
- TIMEOUT=20, grant tags 0 and 3 in the same window, no completions -> to_val for tag 0 at grant+21, then tag 3 on a later cycle in index order; outstanding returns to 0.
- Fill all 32 tags -> tag_avail=0 and alloc_req ignored; retire tag 17 -> next grant returns tag 17.
- Assert flush with 10 tags outstanding -> outstanding=0 on the next cycle, with no done or timeout pulses; alloc_len=0 then a 1024-DW cpl -> done with no cpl_err.

Source files
------------

// File: rtl/sfif_tag_pool.sv
// rtl/sfif_tag_pool.sv - non-posted tag pool with per-tag completion tracking and timeout
module sfif_tag_pool #(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = 5,
  parameter int LEN_W    = 10,
  parameter int TO_W     = 16,
  parameter int TIMEOUT  = 50000
) (
  input  logic             clk_125,
  input  logic             rstn,
  input  logic             flush,
  input  logic             alloc_req,
  input  logic [LEN_W-1:0] alloc_len,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             tag_avail,
  input  logic             cpl_val,
  input  logic [TAG_W-1:0] cpl_tag,
  input  logic [LEN_W-1:0] cpl_len,
  output logic             done_val,
  output logic [TAG_W-1:0] done_tag,
  output logic             to_val,
  output logic [TAG_W-1:0] to_tag,
  output logic             cpl_err,
  output logic [TAG_W:0]   outstanding
);
  localparam logic [TO_W-1:0] AGE_LAST = TO_W'(TIMEOUT - 1);

  logic [NUM_TAGS-1:0] busy, busy_n, expired, expired_n, retire;
  logic [LEN_W:0]      rem   [NUM_TAGS];
  logic [LEN_W:0]      rem_n [NUM_TAGS];
  logic [TO_W-1:0]     age   [NUM_TAGS];
  logic [TO_W-1:0]     age_n [NUM_TAGS];
  logic [LEN_W:0]      alloc_dw, cpl_dw;
  logic                done_n, to_n, err_n, cpl_hit;
  logic [TAG_W-1:0]    done_tag_n, to_tag_n, to_sel;
  logic [TAG_W:0]      count_n;

  // A zero length field means the maximum 2**LEN_W DW.
  assign alloc_dw  = (alloc_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, alloc_len};
  assign cpl_dw    = (cpl_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cpl_len};
  assign tag_avail = ~&busy;
  assign alloc_gnt = alloc_req & tag_avail & ~flush;

  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (!busy[i]) alloc_tag = TAG_W'(i);
  end

  always_comb begin
    busy_n     = busy;
    expired_n  = expired;
    rem_n      = rem;
    age_n      = age;
    retire     = '0;
    cpl_hit    = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    done_tag_n = done_tag;
    to_sel     = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      if (busy[i] && !expired[i]) begin
        if (age[i] == AGE_LAST) expired_n[i] = 1'b1;
        else                    age_n[i] = age[i] + 1'b1;
      end
    for (int i = 0; i < NUM_TAGS; i++)
      if (cpl_val && busy[i] && cpl_tag == TAG_W'(i)) begin
        cpl_hit = 1'b1;
        if (cpl_dw < rem[i]) begin
          rem_n[i] = rem[i] - cpl_dw;
        end else begin
          retire[i]    = 1'b1;
          busy_n[i]    = 1'b0;
          expired_n[i] = 1'b0;
          done_n       = 1'b1;
          done_tag_n   = cpl_tag;
          err_n        = (cpl_dw > rem[i]);
        end
      end
    if (cpl_val && !cpl_hit) err_n = 1'b1;
    // A tag retired by its final completion this cycle drops its pending timeout report.
    to_n = |(expired & ~retire);
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (expired[i] && !retire[i]) to_sel = TAG_W'(i);
    to_tag_n = to_n ? to_sel : to_tag;
    for (int i = 0; i < NUM_TAGS; i++)
      if (to_n && to_sel == TAG_W'(i)) begin
        busy_n[i]    = 1'b0;
        expired_n[i] = 1'b0;
      end
    for (int i = 0; i < NUM_TAGS; i++)
      if (alloc_gnt && alloc_tag == TAG_W'(i)) begin
        busy_n[i]    = 1'b1;
        expired_n[i] = 1'b0;
        age_n[i]     = '0;
        rem_n[i]     = alloc_dw;
      end
    count_n = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      count_n = count_n + (TAG_W + 1)'(busy_n[i]);
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      busy        <= '0;
      expired     <= '0;
      done_val    <= 1'b0;
      done_tag    <= '0;
      to_val      <= 1'b0;
      to_tag      <= '0;
      cpl_err     <= 1'b0;
      outstanding <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        rem[i] <= '0;
        age[i] <= '0;
      end
    end else if (flush) begin
      busy        <= '0;
      expired     <= '0;
      done_val    <= 1'b0;
      done_tag    <= '0;
      to_val      <= 1'b0;
      to_tag      <= '0;
      cpl_err     <= 1'b0;
      outstanding <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        rem[i] <= '0;
        age[i] <= '0;
      end
    end else begin
      busy        <= busy_n;
      expired     <= expired_n;
      done_val    <= done_n;
      done_tag    <= done_tag_n;
      to_val      <= to_n;
      to_tag      <= to_tag_n;
      cpl_err     <= err_n;
      outstanding <= count_n;
      for (int i = 0; i < NUM_TAGS; i++) begin
        rem[i] <= rem_n[i];
        age[i] <= age_n[i];
      end
    end
  end
endmodule

// File: tb/tb_sfif_tag_pool.sv
// tb/tb_sfif_tag_pool.sv - directed and random bench for sfif_tag_pool against a deadline-based model
module tb_sfif_tag_pool;
  localparam int NT = 32, TAG_W = 5, LEN_W = 10, TO_W = 16, TMO = 40;

  logic clk_125 = 1'b0, rstn = 1'b0, flush = 1'b0, alloc_req = 1'b0, cpl_val = 1'b0;
  logic [LEN_W-1:0] alloc_len = '0, cpl_len = '0;
  logic [TAG_W-1:0] cpl_tag = '0;
  logic alloc_gnt, tag_avail, done_val, to_val, cpl_err;
  logic [TAG_W-1:0] alloc_tag, done_tag, to_tag;
  logic [TAG_W:0] outstanding;

  sfif_tag_pool #(.NUM_TAGS(NT), .TAG_W(TAG_W), .LEN_W(LEN_W), .TO_W(TO_W), .TIMEOUT(TMO)) dut (
    .clk_125(clk_125), .rstn(rstn), .flush(flush), .alloc_req(alloc_req), .alloc_len(alloc_len),
    .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .tag_avail(tag_avail), .cpl_val(cpl_val),
    .cpl_tag(cpl_tag), .cpl_len(cpl_len), .done_val(done_val), .done_tag(done_tag),
    .to_val(to_val), .to_tag(to_tag), .cpl_err(cpl_err), .outstanding(outstanding));

  always #4 clk_125 = ~clk_125;

  int checks = 0, errors = 0;
  // Model: a busy tag times out once the edge count passes its grant edge by more than TMO.
  bit mb [NT];
  int mrem [NT];
  int mg [NT];
  int edge_n;
  bit e_done, e_to, e_err;
  int e_done_tag, e_to_tag, e_out;
  logic [31:0] obs_tag;
  logic obs_avail;

  task automatic chk(input string name, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin mb[i] = 0; mrem[i] = 0; mg[i] = 0; end
    edge_n = 0;
  endtask

  task automatic idle();
    alloc_req = 0; alloc_len = '0; cpl_val = 0; cpl_tag = '0; cpl_len = '0; flush = 0;
  endtask

  task automatic step();
    int ft, l, t, cnt;
    bit gnt;
    @(negedge clk_125);
    ft = -1;
    for (int i = NT - 1; i >= 0; i--) if (!mb[i]) ft = i;
    gnt = alloc_req && (ft >= 0) && !flush;
    obs_avail = tag_avail;
    obs_tag = alloc_gnt ? 32'(alloc_tag) : 32'hFFFF_FFFF;
    chk("tag_avail", tag_avail, int'(ft >= 0));
    chk("alloc_gnt", alloc_gnt, int'(gnt));
    if (ft >= 0) chk("alloc_tag", alloc_tag, ft);
    edge_n++;
    e_done = 0; e_to = 0; e_err = 0;
    if (flush) begin
      for (int i = 0; i < NT; i++) mb[i] = 0;
    end else begin
      if (cpl_val) begin
        t = int'(cpl_tag);
        l = (cpl_len == 0) ? 1024 : int'(cpl_len);
        if (t >= NT || !mb[t]) e_err = 1;
        else if (l < mrem[t]) mrem[t] -= l;
        else begin
          e_done = 1; e_done_tag = t; e_err = (l > mrem[t]); mb[t] = 0;
        end
      end
      for (int i = 0; i < NT; i++)
        if (mb[i] && edge_n > mg[i] + TMO) begin
          mb[i] = 0; e_to = 1; e_to_tag = i; break;
        end
      if (gnt) begin
        mb[ft] = 1; mrem[ft] = (alloc_len == 0) ? 1024 : int'(alloc_len); mg[ft] = edge_n;
      end
    end
    cnt = 0;
    for (int i = 0; i < NT; i++) cnt += int'(mb[i]);
    e_out = cnt;
    @(posedge clk_125);
    #1;
    chk("done_val", done_val, int'(e_done));
    if (e_done) chk("done_tag", done_tag, e_done_tag);
    chk("to_val", to_val, int'(e_to));
    if (e_to) chk("to_tag", to_tag, e_to_tag);
    chk("cpl_err", cpl_err, int'(e_err));
    chk("outstanding", outstanding, e_out);
  endtask

  task automatic rand_inputs();
    int bl[$];
    int t, r;
    alloc_req = ($urandom_range(0, 99) < 40);
    alloc_len = ($urandom_range(0, 7) == 0) ? '0 : LEN_W'($urandom_range(1, 12));
    cpl_val = ($urandom_range(0, 99) < 50);
    flush = ($urandom_range(0, 199) == 0);
    for (int i = 0; i < NT; i++) if (mb[i]) bl.push_back(i);
    if (bl.size() > 0 && $urandom_range(0, 7) != 0) begin
      t = bl[$urandom_range(0, bl.size() - 1)];
      r = (mrem[t] + 1 > 1023) ? 1023 : mrem[t] + 1;
      cpl_tag = TAG_W'(t);
      cpl_len = ($urandom_range(0, 15) == 0) ? '0 : LEN_W'($urandom_range(1, r));
    end else begin
      cpl_tag = TAG_W'($urandom_range(0, NT - 1));
      cpl_len = LEN_W'($urandom_range(1, 8));
    end
  endtask

  initial begin
    int g0, e0, e3;
    model_reset();
    repeat (3) @(posedge clk_125);
    #1;
    chk("rst_tag_avail", tag_avail, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_done_val", done_val, 0);
    chk("rst_to_val", to_val, 0);
    chk("rst_cpl_err", cpl_err, 0);
    chk("rst_done_tag", done_tag, 0);
    chk("rst_to_tag", to_tag, 0);
    rstn = 1;

    idle(); alloc_req = 1; alloc_len = 4;
    for (int k = 0; k < 3; k++) begin step(); chk("grant_seq", obs_tag, k); end
    chk("outstanding_3", outstanding, 3);

    idle(); cpl_val = 1; cpl_tag = 1; cpl_len = 4; step();
    idle(); alloc_req = 1; alloc_len = 8; step(); chk("regrant_t1", obs_tag, 1);
    idle(); cpl_val = 1; cpl_tag = 1; cpl_len = 5; step();
    chk("partial_no_done", done_val, 0);
    cpl_len = 3; step();
    chk("t1_done_val", done_val, 1);
    chk("t1_done_tag", done_tag, 1);
    chk("t1_no_err", cpl_err, 0);
    idle(); alloc_req = 1; alloc_len = 4; step(); chk("regrant_t1b", obs_tag, 1);

    idle(); cpl_val = 1; cpl_tag = 7; cpl_len = 1; step();
    chk("free_tag_err", cpl_err, 1);
    chk("free_tag_no_done", done_val, 0);
    cpl_tag = 0; cpl_len = 6; step();
    chk("overrun_err", cpl_err, 1);
    chk("overrun_done", done_val, 1);
    chk("overrun_tag", done_tag, 0);

    idle(); flush = 1; step(); idle();
    alloc_req = 1; alloc_len = 4;
    step(); g0 = edge_n;
    repeat (3) step();
    idle(); cpl_val = 1; cpl_len = 4; cpl_tag = 1; step();
    cpl_tag = 2; step();
    idle();
    e0 = -1; e3 = -1;
    for (int k = 0; k < 80 && e3 < 0; k++) begin
      step();
      if (to_val && to_tag == 0 && e0 < 0) e0 = edge_n;
      if (to_val && to_tag == 3 && e3 < 0) e3 = edge_n;
    end
    chk("to_tag0_edge", e0, g0 + TMO + 1);
    chk("to_tag3_edge", e3, g0 + 3 + TMO + 1);
    chk("to_drain_out", outstanding, 0);

    idle(); alloc_req = 1; alloc_len = 2;
    repeat (NT) step();
    chk("full_out", outstanding, NT);
    step();
    chk("full_avail", obs_avail, 0);
    chk("full_no_gnt", obs_tag, -1);
    idle(); cpl_val = 1; cpl_tag = 17; cpl_len = 2; step();
    idle(); alloc_req = 1; alloc_len = 2; step(); chk("regrant_t17", obs_tag, 17);

    idle(); flush = 1; step(); idle();
    alloc_req = 1; alloc_len = 5; repeat (10) step();
    chk("pre_flush_out", outstanding, 10);
    idle(); flush = 1; step();
    chk("flush_out", outstanding, 0);
    chk("flush_no_done", done_val, 0);
    chk("flush_no_to", to_val, 0);
    idle(); alloc_req = 1; alloc_len = 0; step();
    idle(); cpl_val = 1; cpl_tag = 0; cpl_len = 0; step();
    chk("max_len_done", done_val, 1);
    chk("max_len_no_err", cpl_err, 0);

    for (int k = 0; k < 800; k++) begin rand_inputs(); step(); end

    idle(); alloc_req = 1; alloc_len = 3; repeat (5) step(); idle();
    @(negedge clk_125);
    #1 rstn = 0;
    #1;
    chk("arst_out", outstanding, 0);
    chk("arst_avail", tag_avail, 1);
    chk("arst_done", done_val, 0);
    chk("arst_to", to_val, 0);
    chk("arst_err", cpl_err, 0);
    model_reset();
    @(posedge clk_125);
    #1 rstn = 1;
    for (int k = 0; k < 200; k++) begin rand_inputs(); step(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
